// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - NUM_PROD-product quarter vending controller with credit, cancel/refund and serial change.
// Optional per-product stock tracking (restock/sold_out ports) is built when VEND_STOCK_EN is defined.
module vend_ctrl_multi #(
  parameter int NUM_PROD   = 4,
  parameter int CREDIT_W   = 3,
  parameter int MAX_CREDIT = 7,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {3'd4, 3'd3, 3'd2, 3'd3}
`ifdef VEND_STOCK_EN
  , parameter int STOCK_INIT = 4
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coin_in,
  input  logic [NUM_PROD-1:0]         sel,
  input  logic                        cancel,
`ifdef VEND_STOCK_EN
  input  logic                        restock,
  output logic [NUM_PROD-1:0]         sold_out,
`endif
  output logic [CREDIT_W-1:0]         credit,
  output logic                        vend_valid,
  output logic [$clog2(NUM_PROD)-1:0] vend_id,
  output logic                        change_out,
  output logic                        coin_reject,
  output logic                        busy
);

  localparam int ID_W = $clog2(NUM_PROD);
  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     vend_id_q, vend_id_d;
  logic                vend_valid_q, vend_valid_d;
  logic                change_out_q, change_out_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price [NUM_PROD];
  logic [ID_W-1:0]     sel_idx;
  logic                sel_onehot;
  logic                avail;

  for (genvar k = 0; k < NUM_PROD; k++) begin : g_price
    assign price[k] = PRICES[k*CREDIT_W +: CREDIT_W];
  end

  assign sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel[i]) sel_idx = ID_W'(i);
    end
  end

`ifdef VEND_STOCK_EN
  localparam int STOCK_W = $clog2(STOCK_INIT + 1);
  logic [STOCK_W-1:0] stock_q [NUM_PROD];
  logic               restock_go;
  logic               vend_go;

  // Restock only wins an IDLE cycle that nothing of higher priority claimed.
  assign restock_go = (state_q == IDLE) && (state_d == IDLE) && restock && !coin_in && !cancel;
  assign vend_go    = (state_q == IDLE) && (state_d == VEND);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROD; i++) begin
      if (reset || restock_go) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else if (vend_go && (sel_idx == ID_W'(i))) begin
        stock_q[i] <= stock_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      sold_out[i] = (stock_q[i] == '0);
    end
  end

  assign avail = !sold_out[sel_idx];
`else
  assign avail = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    vend_valid_d  = 1'b0;
    change_out_d  = 1'b0;
    coin_reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coin_in) begin
          if (credit_q == MAX_C) coin_reject_d = 1'b1;
          else                   credit_d      = credit_q + 1'b1;
        end else if (cancel && (credit_q != '0)) begin
          state_d      = CHANGE;
          credit_d     = credit_q - 1'b1;
          change_out_d = 1'b1;
        end else if (sel_onehot && (credit_q >= price[sel_idx]) && avail) begin
          state_d      = VEND;
          credit_d     = credit_q - price[sel_idx];
          vend_id_d    = sel_idx;
          vend_valid_d = 1'b1;
        end
      end
      VEND, CHANGE: begin
        coin_reject_d = coin_in;
        // Each returned quarter is debited on the edge that raises its change_out pulse.
        if (credit_q != '0) begin
          state_d      = CHANGE;
          credit_d     = credit_q - 1'b1;
          change_out_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_id_q     <= '0;
      vend_valid_q  <= 1'b0;
      change_out_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_id_q     <= vend_id_d;
      vend_valid_q  <= vend_valid_d;
      change_out_q  <= change_out_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign vend_valid  = vend_valid_q;
  assign vend_id     = vend_id_q;
  assign change_out  = change_out_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - scoreboard bench for vend_ctrl_multi; stock scenario built when VEND_STOCK_EN is defined.
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_in = 1'b0;
  logic [3:0] sel = '0;
  logic       cancel = 1'b0;
  logic [2:0] credit;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       change_out;
  logic       coin_reject;
  logic       busy;
`ifdef VEND_STOCK_EN
  logic       restock = 1'b0;
  logic [3:0] sold_out;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int exp_vend[$];
  int exp_chg[$];
  int exp_rej[$];

  always #5 clk = ~clk;

  vend_ctrl_multi #(
    .NUM_PROD(4), .CREDIT_W(3), .MAX_CREDIT(7), .PRICES({3'd4, 3'd3, 3'd2, 3'd3})
`ifdef VEND_STOCK_EN
    , .STOCK_INIT(1)
`endif
  ) dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .sel(sel), .cancel(cancel),
`ifdef VEND_STOCK_EN
    .restock(restock), .sold_out(sold_out),
`endif
    .credit(credit), .vend_valid(vend_valid), .vend_id(vend_id),
    .change_out(change_out), .coin_reject(coin_reject), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every output pulse must match the next expected event of its kind.
  always @(negedge clk) begin
    if (vend_valid) begin
      if (exp_vend.size() == 0) check("vend_unexpected", 1, 0);
      else check("vend_id", 32'(vend_id), 32'(exp_vend.pop_front()));
    end
    if (change_out) begin
      if (exp_chg.size() == 0) check("change_unexpected", 1, 0);
      else check("change_credit", 32'(credit), 32'(exp_chg.pop_front()));
    end
    if (coin_reject) begin
      if (exp_rej.size() == 0) check("reject_unexpected", 1, 0);
      else check("reject_credit", 32'(credit), 32'(exp_rej.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) begin
      coin_in = 1'b1;
      tick();
      coin_in = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] s);
    sel = s;
    tick();
    sel = '0;
  endtask

  task automatic push_change(input int c);
    for (int r = c - 1; r >= 0; r--) exp_chg.push_back(r);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_credit", 32'(credit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_vend", 32'(vend_valid), 0);
    check("rst_change", 32'(change_out), 0);
    check("rst_reject", 32'(coin_reject), 0);

    // 3 coins, buy product 1 (price 2), one quarter back
    coins(3);
    check("t1_credit3", 32'(credit), 3);
    exp_vend.push_back(1);
    push_change(1);
    press(4'b0010);
    check("t1_vend_valid", 32'(vend_valid), 1);
    check("t1_credit_vend", 32'(credit), 1);
    check("t1_busy_vend", 32'(busy), 1);
    tick();
    check("t1_change", 32'(change_out), 1);
    check("t1_busy_chg", 32'(busy), 1);
    tick();
    check("t1_idle", 32'(busy), 0);
    check("t1_credit0", 32'(credit), 0);

    // Saturation at 7, 8th coin rejected, buy product 3 (price 4), 3 back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_rej.push_back(7);
      coins(1);
      check("t2_credit", 32'(credit), (i < 7) ? i + 1 : 7);
    end
    check("t2_reject", 32'(coin_reject), 1);
    exp_vend.push_back(3);
    push_change(3);
    press(4'b1000);
    check("t2_credit_vend", 32'(credit), 3);
    wait_idle("t2_idle");
    check("t2_credit0", 32'(credit), 0);

    // Insufficient credit and non-one-hot select are ignored, then cancel
    do_reset();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t3_cancel0_busy", 32'(busy), 0);
    coins(2);
    press(4'b0001);
    check("t3_poor_busy", 32'(busy), 0);
    check("t3_poor_credit", 32'(credit), 2);
    press(4'b0011);
    check("t3_multi_busy", 32'(busy), 0);
    check("t3_multi_credit", 32'(credit), 2);
    push_change(2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t3_cancel_busy", 32'(busy), 1);
    wait_idle("t3_idle");
    check("t3_credit0", 32'(credit), 0);

    // coin_in beats sel in the same cycle
    do_reset();
    coins(2);
    coin_in = 1'b1;
    sel = 4'b0010;
    tick();
    coin_in = 1'b0;
    sel = '0;
    check("t4_credit", 32'(credit), 3);
    check("t4_no_vend", 32'(vend_valid), 0);
    check("t4_no_busy", 32'(busy), 0);
    push_change(3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_idle("t4_idle");

    // Reset during change forfeits credit; coin during VEND is rejected
    do_reset();
    coins(5);
    exp_vend.push_back(0);
    exp_chg.push_back(1);
    exp_rej.push_back(1);
    press(4'b0001);
    check("t5_credit_vend", 32'(credit), 2);
    coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
    check("t5_change", 32'(change_out), 1);
    check("t5_reject", 32'(coin_reject), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_credit", 32'(credit), 0);
    check("t5_rst_change", 32'(change_out), 0);
    tick();
    tick();
    check("t5_after_change", 32'(change_out), 0);

`ifdef VEND_STOCK_EN
    // Stock of one: vend, sold out, ignored, restock, vend again
    do_reset();
    check("t6_sold_rst", 32'(sold_out), 0);
    coins(3);
    exp_vend.push_back(2);
    press(4'b0100);
    wait_idle("t6_idle1");
    check("t6_sold", 32'(sold_out[2]), 1);
    coins(3);
    press(4'b0100);
    check("t6_ignored_busy", 32'(busy), 0);
    check("t6_ignored_credit", 32'(credit), 3);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    check("t6_restocked", 32'(sold_out[2]), 0);
    exp_vend.push_back(2);
    press(4'b0100);
    check("t6_revend", 32'(vend_valid), 1);
    wait_idle("t6_idle2");
`endif

    tick();
    check("pending_vend", 32'(exp_vend.size()), 0);
    check("pending_change", 32'(exp_chg.size()), 0);
    check("pending_reject", 32'(exp_rej.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
